// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 DIT FFT datapath and its stage controller.
// The optional sequencing stall is enabled by defining FFT_STAGE_CTRL_HOLD_EN.
package fft_pkg;

    localparam int unsigned FFT_DATA_W     = 24;
    localparam int unsigned FFT_TW_W       = 16;
    localparam int unsigned FFT_TW_SHIFT   = 13;
    localparam int unsigned FFT_DEF_LOG2N  = 8;
    localparam int unsigned FFT_DEF_BF_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_t;

    // One RAM read cycle ahead of the butterfly pipeline.
    function automatic int unsigned drain_len(input int unsigned bf_lat);
        return bf_lat + 1;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift line carrying {issue strobe, address pair} from the butterfly issue
// point to the write-back point; freezes while i_hold is high.
module fft_addr_delay #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_hold,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (!i_hold) begin
            r_pipe[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT stage sequencer: issues N/2 butterflies per stage, drains the
// butterfly pipeline between stages. Optional hold input via FFT_STAGE_CTRL_HOLD_EN.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N  = FFT_DEF_LOG2N,
    parameter int unsigned BF_LAT = FFT_DEF_BF_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef FFT_STAGE_CTRL_HOLD_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             done,
    output logic             bf_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [3:0]       stage
);

    localparam int unsigned D  = drain_len(BF_LAT);
    localparam int unsigned KW = LOG2N - 1;
    localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned DW = 2 * LOG2N + 1;

    localparam logic [KW-1:0] K_LAST     = '1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(D - 1);
    localparam logic [3:0]    STAGE_LAST = 4'(LOG2N);

    fft_state_t    r_state;
    fft_state_t    w_state_nx;
    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k_nx;
    logic [3:0]    r_stage;
    logic [3:0]    w_stage_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          w_hold;

`ifdef FFT_STAGE_CTRL_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_stage <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_k     <= w_k_nx;
            r_stage <= w_stage_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_k_nx     = r_k;
        w_stage_nx = r_stage;
        w_cnt_nx   = r_cnt;
        if (!w_hold) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nx = ST_RUN;
                        w_k_nx     = '0;
                        w_stage_nx = 4'd1;
                        w_cnt_nx   = '0;
                    end
                end
                ST_RUN: begin
                    if (r_k == K_LAST) begin
                        w_state_nx = ST_DRAIN;
                        w_cnt_nx   = '0;
                    end else begin
                        w_k_nx = r_k + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == CNT_LAST) begin
                        if (r_stage == STAGE_LAST) begin
                            w_state_nx = ST_DONE;
                        end else begin
                            w_state_nx = ST_RUN;
                            w_stage_nx = r_stage + 4'd1;
                            w_k_nx     = '0;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nx = ST_IDLE;
                    w_stage_nx = '0;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Butterfly k of stage s: group g = k >> (s-1) starts at g << s, offset j = k & (half-1).
    logic             w_issue;
    logic [3:0]       w_sm1;
    logic [LOG2N-1:0] w_kx;
    logic [LOG2N-1:0] w_half;
    logic [LOG2N-1:0] w_j;
    logic [LOG2N-1:0] w_base;
    logic [LOG2N-1:0] w_a;
    logic [LOG2N-1:0] w_b;
    logic [LOG2N-1:0] w_tw_full;

    always_comb begin
        w_issue   = (r_state == ST_RUN) && !w_hold;
        w_sm1     = r_stage - 4'd1;
        w_kx      = {1'b0, r_k};
        w_half    = LOG2N'(1) << w_sm1;
        w_j       = w_kx & (w_half - LOG2N'(1));
        w_base    = (w_kx >> w_sm1) << r_stage;
        w_a       = w_base | w_j;
        w_b       = w_a | w_half;
        w_tw_full = w_j << (STAGE_LAST - r_stage);
    end

    assign bf_en     = w_issue;
    assign rd_addr_a = w_issue ? w_a : '0;
    assign rd_addr_b = w_issue ? w_b : '0;
    assign tw_addr   = w_issue ? w_tw_full[LOG2N-2:0] : '0;

    assign busy  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done  = (r_state == ST_DONE);
    assign stage = busy ? r_stage : 4'd0;

    logic [DW-1:0] w_dly;

    fft_addr_delay #(
        .DEPTH (D),
        .WIDTH (DW)
    ) u_addr_delay (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_hold (w_hold),
        .i_d    ({bf_en, rd_addr_a, rd_addr_b}),
        .o_q    (w_dly)
    );

    assign wr_en     = w_dly[DW-1] & ~w_hold;
    assign wr_addr_a = w_dly[2*LOG2N-1:LOG2N];
    assign wr_addr_b = w_dly[LOG2N-1:0];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl at LOG2N=3, BF_LAT=2; hold scenario runs when
// FFT_STAGE_CTRL_HOLD_EN is defined.
module tb_fft_stage_ctrl;

    localparam int L  = 3;
    localparam int BL = 2;
    localparam int D  = BL + 1;
    localparam int NH = (1 << L) / 2;

    logic       clk;
    logic       rst;
    logic       start;
`ifdef FFT_STAGE_CTRL_HOLD_EN
    logic       hold;
`endif
    logic       busy;
    logic       done;
    logic       bf_en;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [1:0] tw_addr;
    logic       wr_en;
    logic [2:0] wr_addr_a;
    logic [2:0] wr_addr_b;
    logic [3:0] stage;

    fft_stage_ctrl #(
        .LOG2N  (L),
        .BF_LAT (BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef FFT_STAGE_CTRL_HOLD_EN
        .hold      (hold),
`endif
        .busy      (busy),
        .done      (done),
        .bf_en     (bf_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         cyc;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
        logic [3:0] stg;
    } ev_t;

    ev_t iss_q[$];
    ev_t wr_q[$];
    int  cyc;
    int  busy_lo;
    int  busy_hi;
    int  exp_done;
    bit  mon_en;
    int  n_checks;
    int  n_fail;

    // Reference order: stage, then group, then offset inside group.
    task automatic push_expected(input int base);
        for (int s = 1; s <= L; s++) begin
            int half;
            half = 1 << (s - 1);
            for (int g = 0; g < NH / half; g++) begin
                for (int j = 0; j < half; j++) begin
                    ev_t e;
                    e.cyc = base + (s - 1) * (NH + D) + g * half + j;
                    e.a   = 3'(g * 2 * half + j);
                    e.b   = 3'(g * 2 * half + j + half);
                    e.tw  = 2'(j * (NH / half));
                    e.stg = 4'(s);
                    iss_q.push_back(e);
                    e.cyc = e.cyc + D;
                    wr_q.push_back(e);
                end
            end
        end
        busy_lo  = base;
        busy_hi  = base + L * (NH + D) - 1;
        exp_done = base + L * (NH + D);
    endtask

    task automatic clear_expected();
        iss_q.delete();
        wr_q.delete();
        busy_lo  = 1;
        busy_hi  = 0;
        exp_done = -1;
    endtask

    ev_t mon_e;
    bit  exp_iss;
    bit  exp_wr;
    bit  exp_busy;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_iss = (iss_q.size() > 0) && (iss_q[0].cyc == cyc);
            n_checks++;
            if (bf_en !== exp_iss) begin
                n_fail++;
                $display("FAIL bf_en cyc=%0d got=%b exp=%b", cyc, bf_en, exp_iss);
            end
            if (exp_iss) begin
                mon_e = iss_q.pop_front();
                n_checks++;
                if (rd_addr_a !== mon_e.a || rd_addr_b !== mon_e.b ||
                    tw_addr !== mon_e.tw || stage !== mon_e.stg) begin
                    n_fail++;
                    $display("FAIL issue cyc=%0d got a=%0d b=%0d tw=%0d st=%0d exp a=%0d b=%0d tw=%0d st=%0d",
                             cyc, rd_addr_a, rd_addr_b, tw_addr, stage,
                             mon_e.a, mon_e.b, mon_e.tw, mon_e.stg);
                end
            end else begin
                n_checks++;
                if (rd_addr_a !== 3'd0 || rd_addr_b !== 3'd0 || tw_addr !== 2'd0) begin
                    n_fail++;
                    $display("FAIL idle_addr cyc=%0d got a=%0d b=%0d tw=%0d exp 0",
                             cyc, rd_addr_a, rd_addr_b, tw_addr);
                end
            end

            exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            n_checks++;
            if (wr_en !== exp_wr) begin
                n_fail++;
                $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, wr_en, exp_wr);
            end
            if (exp_wr) begin
                mon_e = wr_q.pop_front();
                n_checks++;
                if (wr_addr_a !== mon_e.a || wr_addr_b !== mon_e.b) begin
                    n_fail++;
                    $display("FAIL write cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d",
                             cyc, wr_addr_a, wr_addr_b, mon_e.a, mon_e.b);
                end
            end

            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
            end
            n_checks++;
            if (done !== (cyc == exp_done)) begin
                n_fail++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, (cyc == exp_done));
            end
            if (!exp_busy) begin
                n_checks++;
                if (stage !== 4'd0) begin
                    n_fail++;
                    $display("FAIL stage_idle cyc=%0d got=%0d exp=0", cyc, stage);
                end
            end
        end
    end

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, bf_en, wr_en, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, stage} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b done=%b bf_en=%b wr_en=%b stage=%0d exp all 0",
                     busy, done, bf_en, wr_en, stage);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || bf_en !== 1'b0 || stage !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold got busy=%b bf_en=%b stage=%0d exp 0 0 0", busy, bf_en, stage);
        end
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_start_ignored_and_back_to_back();
        clear_expected();
        cyc   = 0;
        start = 1'b1;
        push_expected(1);
        for (int c = 1; c <= 47; c++) begin
            @(posedge clk);
            cyc = c;
            #1;
            start = (c == 5 || c == 22 || c == 23);
            if (c == 23) push_expected(24);
        end
        start = 1'b0;
        n_checks++;
        if (iss_q.size() != 0 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_leftover got iss=%0d wr=%0d exp 0 0", iss_q.size(), wr_q.size());
        end
    endtask

    task automatic test_reset_abort();
        clear_expected();
        cyc   = 0;
        start = 1'b1;
        push_expected(1);
        for (int c = 1; c <= 36; c++) begin
            @(posedge clk);
            cyc = c;
            #1;
            start = (c == 12);
            if (c == 10) begin
                rst = 1'b1;
                clear_expected();
                #1;
                n_checks++;
                if ({busy, done, bf_en, wr_en, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, stage} !== '0) begin
                    n_fail++;
                    $display("FAIL abort_outputs got busy=%b bf_en=%b wr_en=%b stage=%0d exp all 0",
                             busy, bf_en, wr_en, stage);
                end
            end
            if (c == 11) rst = 1'b0;
            if (c == 12) push_expected(13);
        end
        start = 1'b0;
        n_checks++;
        if (iss_q.size() != 0 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_leftover got iss=%0d wr=%0d exp 0 0", iss_q.size(), wr_q.size());
        end
    endtask

`ifdef FFT_STAGE_CTRL_HOLD_EN
    task automatic test_hold();
        ev_t t;
        clear_expected();
        cyc   = 0;
        start = 1'b1;
        push_expected(1);
        for (int i = 0; i < iss_q.size(); i++) begin
            t = iss_q[i];
            if (t.cyc >= 3) t.cyc = t.cyc + 2;
            iss_q[i] = t;
        end
        for (int i = 0; i < wr_q.size(); i++) begin
            t = wr_q[i];
            if (t.cyc >= 3) t.cyc = t.cyc + 2;
            wr_q[i] = t;
        end
        busy_hi  = busy_hi + 2;
        exp_done = exp_done + 2;
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk);
            cyc = c;
            #1;
            start = 1'b0;
            hold  = (c == 3 || c == 4);
        end
        hold = 1'b0;
        n_checks++;
        if (iss_q.size() != 0 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL hold_leftover got iss=%0d wr=%0d exp 0 0", iss_q.size(), wr_q.size());
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        cyc      = 0;
        clear_expected();
`ifdef FFT_STAGE_CTRL_HOLD_EN
        hold = 1'b0;
`endif
        test_reset();
        mon_en = 1'b1;
        test_start_ignored_and_back_to_back();
        test_reset_abort();
`ifdef FFT_STAGE_CTRL_HOLD_EN
        test_hold();
`endif
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 SHALL have parameter LOG2N, default 8, meaning log2 of FFT points N (legal 2..12).
REQ-002 SHALL have parameter BF_LAT, default 3, meaning butterfly pipeline latency in cycles from bf_en to result.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, request one full in-place radix-2 DIT FFT pass.
REQ-006 SHALL have port busy, output, 1 bit, high while a transform is sequencing.
REQ-007 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-008 SHALL have port bf_en, output, 1 bit, butterfly issue strobe.
REQ-009 SHALL have ports rd_addr_a and rd_addr_b, outputs, LOG2N bits each, data-RAM read addresses for butterfly inputs a and b.
REQ-010 SHALL have port tw_addr, output, LOG2N-1 bits, twiddle ROM address.
REQ-011 SHALL have ports wr_en (1 bit), wr_addr_a and wr_addr_b (LOG2N bits each), outputs, write-back strobe and addresses.
REQ-012 SHALL have port stage, output, 4 bits, current stage number 1..LOG2N, 0 when idle.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-014 SHALL leave IDLE only when start=1 is sampled in IDLE, entering RUN with stage=1 and k=0; start in any other state SHALL be ignored.
REQ-015 In RUN, each cycle SHALL issue butterfly k (0..N/2-1): bf_en=1, half=2^(stage-1), j=k mod half, g=k/half, rd_addr_a=2*half*g+j, rd_addr_b=rd_addr_a+half, tw_addr=j<<(LOG2N-stage).
REQ-016 After k=N/2-1 SHALL enter DRAIN for D=BF_LAT+1 cycles (1 RAM read cycle plus butterfly) with bf_en=0.
REQ-017 wr_en, wr_addr_a, wr_addr_b SHALL equal bf_en, rd_addr_a, rd_addr_b delayed exactly D cycles.
REQ-018 At DRAIN end SHALL go to RUN with stage+1, k=0, or to DONE if stage=LOG2N; next-stage reads thus never precede prior-stage writes.
REQ-019 DONE SHALL last one cycle with done=1, busy=0, then return to IDLE; busy=1 exactly in RUN and DRAIN.
REQ-020 Total busy cycles SHALL be LOG2N*(N/2+D).
REQ-021 Outputs rd_addr_a/b and tw_addr SHALL be 0 whenever bf_en=0.

Reset
REQ-022 rst=1 SHALL asynchronously force IDLE, clear k, stage, delay line, and drive every output to 0.
REQ-023 Reset mid-transform SHALL abort with no done pulse and no further wr_en; the next start SHALL begin at stage 1.

Configuration
REQ-024 With macro FFT_STAGE_CTRL_HOLD_EN defined, the module SHALL have input hold (1 bit); hold=1 SHALL freeze state, k, stage, DRAIN counter and delay line, forcing bf_en=0 and wr_en=0 for that cycle and resuming exactly where it stopped.
REQ-025 Without FFT_STAGE_CTRL_HOLD_EN, port hold SHALL be absent and behaviour identical to hold=0.

Structure
REQ-026 Shared package fft_pkg SHALL hold the state encoding, data width 24, twiddle width 16, twiddle scale shift 13, and default LOG2N/BF_LAT.
REQ-027 The D-cycle delay of {bf_en, rd_addr_a, rd_addr_b} SHALL be sub-module fft_addr_delay (parameterised depth/width, async reset, hold-aware).

Verification (LOG2N=3, BF_LAT=2, D=3; start sampled at cycle 0)
REQ-028 Stage 1: cycles 1-4 issue a=0,2,4,6 b=1,3,5,7 tw=0,0,0,0; cycles 5-7 bf_en=0; wr_en cycles 4-7 with same address pairs.
REQ-029 Stages 2/3: cycles 8-11 a=0,1,4,5 b=2,3,6,7 tw=0,2,0,2; cycles 15-18 a=0,1,2,3 b=4,5,6,7 tw=0,1,2,3; last wr_en cycle 21; done=1 cycle 22 only; busy cycles 1-21.
REQ-030 start pulsed at cycles 5 and 22 -> ignored, no restart, sequence unchanged; start at cycle 23 -> new transform, first issue cycle 24.
REQ-031 rst asserted at cycle 10 -> all outputs 0 immediately, no done; start at cycle 12 -> stage 1 issues from cycle 13.
REQ-032 HOLD_EN build, hold=1 cycles 3-4 -> no issue/write those cycles; issue k=2 at cycle 5; every later event shifted 2 cycles, done at cycle 24.
